bus_spi_master: RTL and testbench



---
 rtl/bus_spi_master_pkg.sv | 37 +++
 rtl/bus_spi_master_if.sv | 36 +++
 rtl/bus_spi_phase_cnt.sv | 40 ++++
 rtl/bus_spi_master.sv | 193 +++++++++++++++++++
 tb/tb_bus_spi_master.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_spi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_spi_pkg
//  Purpose  : Shared types and constants for the bus_spi_master SPI engine:
//             FSM state encoding, default word width and mode-0 idle levels.
//  Revision : 1.0  initial release
// ============================================================================
package bus_spi_pkg;

    localparam int c_DEF_DATA_WIDTH = 32;

    // Mode 0 (CPOL=0): SCK rests low, CS inactive high, MOSI parked low.
    localparam logic c_SCK_IDLE  = 1'b0;
    localparam logic c_MOSI_IDLE = 1'b0;
    localparam logic c_CS_N_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5,
        WAIT_REL = 3'd6
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_spi_master_if
//  Purpose  : Bundles the sequencer handshake (data_in/enable/busy/data_out)
//             and the four SPI pins of the bus_spi_master engine.
//  Modports : master - the SPI engine (drives busy, data_out, SCK/MOSI/CS_n)
//             slave  - the surrounding logic (drives data_in, enable, MISO)
//  Revision : 1.0  initial release
// ============================================================================
interface bus_spi_master_if
    import bus_spi_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic                  enable;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_cs_n;
    logic                  spi_miso;

    modport master (
        input  data_in, enable, spi_miso,
        output busy, data_out, spi_sck, spi_mosi, spi_cs_n
    );

    modport slave (
        output data_in, enable, spi_miso,
        input  busy, data_out, spi_sck, spi_mosi, spi_cs_n
    );

endinterface
`default_nettype wire

// File: rtl/bus_spi_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : bus_spi_phase_cnt
//  Purpose  : Loadable down-counter with terminal indication. Loading N-1 on
//             entry to a phase makes o_tc true in the N-th cycle of it, so
//             the FSM leaves the phase after exactly N cycles.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             i_load       - load i_load_val (has priority over counting)
//             i_load_val   - value to load
//             o_tc         - count has reached zero
//  Revision : 1.0  initial release
// ============================================================================
module bus_spi_phase_cnt
    import bus_spi_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/bus_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : bus_spi_master
//  Purpose  : Mode-0 SPI master shift engine. One DATA_WIDTH word per
//             enable/busy handshake, shifted MSB-first on MOSI while the MISO
//             word is captured on each SCK rising edge.
//  Ports    : clk_in - clock (spi_clk domain)
//             reset  - synchronous active-high reset
//             bus    - bus_spi_master_if.master (handshake + SPI pins)
//  Revision : 1.0  initial release
// ============================================================================
module bus_spi_master
    import bus_spi_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int CLK_DIV    = 2,
    parameter int CS_SETUP   = 1,
    parameter int CS_HOLD    = 1,
    parameter int CS_IDLE    = 1
) (
    input  wire              clk_in,
    input  wire              reset,
    bus_spi_master_if.master bus
);

    // One shared phase timer covers SETUP, both SCK half-periods, HOLD, GAP.
    localparam int c_CNT_MAX = max4(CS_SETUP, CLK_DIV, CS_HOLD, CS_IDLE);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HALF  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_LD_IDLE  = c_CNT_W'(CS_IDLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

    state_t                  r_state,    w_state_nxt;
    logic                    r_busy,     w_busy_nxt;
    logic                    r_sck,      w_sck_nxt;
    logic                    r_mosi,     w_mosi_nxt;
    logic                    r_cs_n,     w_cs_n_nxt;
    logic                    r_armed,    w_armed_nxt;
    logic [DATA_WIDTH-1:0]   r_data_out, w_data_out_nxt;
    logic [DATA_WIDTH-1:0]   r_tx,       w_tx_nxt;
    logic [DATA_WIDTH-1:0]   r_rx,       w_rx_nxt;
    logic [c_BIT_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;

    logic                    w_load;
    logic [c_CNT_W-1:0]      w_load_val;
    logic                    w_tc;

    bus_spi_phase_cnt #(
        .WIDTH (c_CNT_W)
    ) u_phase_cnt (
        .clk        (clk_in),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_sck      <= c_SCK_IDLE;
            r_mosi     <= c_MOSI_IDLE;
            r_cs_n     <= c_CS_N_IDLE;
            r_armed    <= 1'b1;
            r_data_out <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_armed    <= w_armed_nxt;
            r_data_out <= w_data_out_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        // Any low cycle of enable re-arms; the sequencer's one-cycle drop
        // between words relies on this being state independent.
        w_armed_nxt    = r_armed | ~bus.enable;
        w_data_out_nxt = r_data_out;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_load         = 1'b0;
        w_load_val     = '0;

        case (r_state)
            IDLE: begin
                if (bus.enable && r_armed) begin
                    w_state_nxt   = SETUP;
                    w_busy_nxt    = 1'b1;
                    w_cs_n_nxt    = 1'b0;
                    w_mosi_nxt    = bus.data_in[DATA_WIDTH-1];
                    w_tx_nxt      = bus.data_in;
                    w_rx_nxt      = '0;
                    w_bit_cnt_nxt = '0;
                    w_armed_nxt   = 1'b0;
                    w_load        = 1'b1;
                    w_load_val    = c_LD_SETUP;
                end
            end

            SETUP: begin
                if (w_tc) begin
                    w_state_nxt = SHIFT_LO;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_HALF;
                end
            end

            SHIFT_LO: begin
                if (w_tc) begin
                    w_state_nxt = SHIFT_HI;
                    w_sck_nxt   = 1'b1;
                    w_rx_nxt    = {r_rx[DATA_WIDTH-2:0], bus.spi_miso};
                    w_load      = 1'b1;
                    w_load_val  = c_LD_HALF;
                end
            end

            SHIFT_HI: begin
                if (w_tc) begin
                    w_sck_nxt     = 1'b0;
                    w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
                    w_load        = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = HOLD;
                        w_load_val  = c_LD_HOLD;
                    end else begin
                        // MOSI advances on the same edge SCK falls.
                        w_state_nxt = SHIFT_LO;
                        w_tx_nxt    = {r_tx[DATA_WIDTH-2:0], 1'b0};
                        w_mosi_nxt  = r_tx[DATA_WIDTH-2];
                        w_load_val  = c_LD_HALF;
                    end
                end
            end

            HOLD: begin
                if (w_tc) begin
                    w_state_nxt = GAP;
                    w_cs_n_nxt  = c_CS_N_IDLE;
                    w_mosi_nxt  = c_MOSI_IDLE;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_IDLE;
                end
            end

            GAP: begin
                if (w_tc) begin
                    w_busy_nxt     = 1'b0;
                    w_data_out_nxt = r_rx;
                    w_state_nxt    = bus.enable ? WAIT_REL : IDLE;
                end
            end

            WAIT_REL: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.data_out = r_data_out;
    assign bus.spi_sck  = r_sck;
    assign bus.spi_mosi = r_mosi;
    assign bus.spi_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_bus_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_spi_master
//  Purpose  : Self-checking bench for bus_spi_master. Two instances: default
//             parameters (32 bit, CLK_DIV=2) and a 16-bit CLK_DIV=1,
//             CS_SETUP=2 variant. Expected values come from transfer-level
//             rules: duration formula, MSB-first bit order, data_out equals
//             the MISO bits presented at each SCK rise.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_spi_master;

    localparam int P0_W = 32, P0_DIV = 2, P0_SU = 1, P0_HO = 1, P0_ID = 1;
    localparam int P1_W = 16, P1_DIV = 1, P1_SU = 2, P1_HO = 1, P1_ID = 1;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic loop0  = 1'b0;
    logic miso0  = 1'b0;
    logic miso1  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    bus_spi_master_if #(.DATA_WIDTH(P0_W)) bus0 ();
    bus_spi_master_if #(.DATA_WIDTH(P1_W)) bus1 ();

    assign bus0.spi_miso = loop0 ? bus0.spi_mosi : miso0;
    assign bus1.spi_miso = miso1;

    bus_spi_master #(
        .DATA_WIDTH (P0_W), .CLK_DIV (P0_DIV), .CS_SETUP (P0_SU),
        .CS_HOLD (P0_HO), .CS_IDLE (P0_ID)
    ) dut0 (
        .clk_in (clk_in),
        .reset  (rst),
        .bus    (bus0)
    );

    bus_spi_master #(
        .DATA_WIDTH (P1_W), .CLK_DIV (P1_DIV), .CS_SETUP (P1_SU),
        .CS_HOLD (P1_HO), .CS_IDLE (P1_ID)
    ) dut1 (
        .clk_in (clk_in),
        .reset  (rst),
        .bus    (bus1)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] miso_pat;
        bit          loop;
        logic [31:0] exp_dout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic en, input logic [31:0] word);
        if (d == 0) begin
            bus0.enable  = en;
            bus0.data_in = word;
        end else begin
            bus1.enable  = en;
            bus1.data_in = word[15:0];
        end
    endtask

    task automatic set_en(input int d, input logic en);
        if (d == 0) bus0.enable = en;
        else        bus1.enable = en;
    endtask

    task automatic set_miso(input int d, input bit loop, input logic v);
        if (d == 0) begin
            loop0 = loop;
            miso0 = v;
        end else begin
            miso1 = v;
        end
    endtask

    task automatic get(input int d, output logic b, output logic c, output logic s,
                       output logic m, output logic [31:0] q);
        if (d == 0) begin
            b = bus0.busy; c = bus0.spi_cs_n; s = bus0.spi_sck;
            m = bus0.spi_mosi; q = bus0.data_out;
        end else begin
            b = bus1.busy; c = bus1.spi_cs_n; s = bus1.spi_sck;
            m = bus1.spi_mosi; q = {16'h0, bus1.data_out};
        end
    endtask

    // One full transfer, entered on a negedge with the DUT armed.
    task automatic xfer(input int d, input logic [31:0] word, input logic [31:0] pat,
                        input bit loop, input logic [31:0] exp_dout,
                        input int chg_bit, input logic [31:0] chg_word, input string tag);
        int w, div, su, ho, id, exp_busy;
        int busy_cyc, csn_cyc, rises, lat, last_rise, cyc;
        bit period_ok, started, done;
        logic b, c, s, m, s_prev;
        logic [31:0] q, mosi_bits, mask;
        if (d == 0) begin w = P0_W; div = P0_DIV; su = P0_SU; ho = P0_HO; id = P0_ID; end
        else        begin w = P1_W; div = P1_DIV; su = P1_SU; ho = P1_HO; id = P1_ID; end
        exp_busy  = su + 2 * div * w + ho + id;
        mask      = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        busy_cyc  = 0; csn_cyc = 0; rises = 0; last_rise = -1; cyc = 0;
        period_ok = 1'b1; started = 1'b0; done = 1'b0; s_prev = 1'b0;
        mosi_bits = '0; b = 1'b0; c = 1'b1; s = 1'b0; m = 1'b0; q = '0;
        set_miso(d, loop, pat[w-1]);
        drive(d, 1'b1, word);
        lat = 0;
        while (!started && lat < 8) begin
            @(negedge clk_in);
            lat++;
            get(d, b, c, s, m, q);
            if (b) started = 1'b1;
        end
        chk({tag, " start_latency"}, 64'(lat), 64'd1);
        chk({tag, " cs_n_at_start"}, {63'd0, c}, 64'd0);
        while (started && !done && cyc < 2000) begin
            if (b)  busy_cyc++;
            if (!c) csn_cyc++;
            if (s && !s_prev) begin
                if (last_rise >= 0 && (cyc - last_rise) != 2 * div) period_ok = 1'b0;
                last_rise = cyc;
                mosi_bits = {mosi_bits[30:0], m};
                rises++;
                if (rises == chg_bit) drive(d, 1'b1, chg_word);
            end
            s_prev = s;
            if (!b) begin
                done = 1'b1;
            end else begin
                set_miso(d, loop, (rises < w) ? pat[w-1-rises] : 1'b0);
                @(negedge clk_in);
                cyc++;
                get(d, b, c, s, m, q);
            end
        end
        chk({tag, " completed"},   {63'd0, done}, 64'd1);
        chk({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
        chk({tag, " cs_n_low"},    64'(csn_cyc), 64'(exp_busy - id));
        chk({tag, " sck_rises"},   64'(rises), 64'(w));
        chk({tag, " sck_period"},  {63'd0, period_ok}, 64'd1);
        chk({tag, " mosi_word"},   {32'd0, mosi_bits & mask}, {32'd0, word & mask});
        chk({tag, " data_out"},    {32'd0, q}, {32'd0, exp_dout & mask});
    endtask

    // Drop enable for exactly one cycle, as the upstream sequencer does.
    task automatic rearm(input int d);
        set_en(d, 1'b0);
        @(negedge clk_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        logic        b, c, s, m, sp;
        logic [31:0] q, wd, pt;
        int          k, r, viol;

        tbl[0] = '{32'hA5C3_1E7F, 32'h0000_0000, 1'b1, 32'hA5C3_1E7F};
        tbl[1] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5678};
        tbl[2] = '{32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F};
        tbl[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};

        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (3) @(negedge clk_in);
        for (int d = 0; d < 2; d++) begin
            get(d, b, c, s, m, q);
            chk($sformatf("reset%0d busy", d), {63'd0, b}, 64'd0);
            chk($sformatf("reset%0d cs_n", d), {63'd0, c}, 64'd1);
            chk($sformatf("reset%0d sck", d),  {63'd0, s}, 64'd0);
            chk($sformatf("reset%0d mosi", d), {63'd0, m}, 64'd0);
            chk($sformatf("reset%0d dout", d), {32'd0, q}, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk_in);
        get(0, b, c, s, m, q);
        chk("idle_no_enable busy", {63'd0, b}, 64'd0);

        // Table-driven transfers with the sequencer's one-cycle re-arm.
        for (int i = 0; i < 4; i++) begin
            xfer(0, tbl[i].din, tbl[i].miso_pat, tbl[i].loop, tbl[i].exp_dout,
                 -1, '0, $sformatf("vec%0d", i));
            rearm(0);
        end

        // Randomized transfers against the transfer-level model.
        for (int i = 0; i < 6; i++) begin
            wd = $urandom;
            pt = $urandom;
            xfer(0, wd, pt, 1'b0, pt, -1, '0, $sformatf("rand%0d", i));
            rearm(0);
        end

        // Enable held high after completion must not retrigger.
        xfer(0, 32'h5555_AAAA, 32'h0, 1'b1, 32'h5555_AAAA, -1, '0, "pre_hold");
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_in);
            get(0, b, c, s, m, q);
            if (b || !c) viol++;
        end
        chk("no_retrigger", 64'(viol), 64'd0);
        rearm(0);

        // data_in changes after the start edge are ignored.
        xfer(0, 32'hFFFF_0000, 32'h0, 1'b1, 32'hFFFF_0000, 5, 32'h0000_FFFF, "din_stable");
        rearm(0);

        // Reset one cycle during the 10th bit, enable kept high.
        drive(0, 1'b1, 32'hC3C3_5A5A);
        loop0 = 1'b1;
        r = 0; k = 0; sp = 1'b0;
        while (r < 10 && k < 500) begin
            @(negedge clk_in);
            k++;
            get(0, b, c, s, m, q);
            if (s && !sp) r++;
            sp = s;
        end
        chk("rst_reach_bit10", 64'(r), 64'd10);
        rst = 1'b1;
        @(negedge clk_in);
        get(0, b, c, s, m, q);
        chk("midrst busy", {63'd0, b}, 64'd0);
        chk("midrst cs_n", {63'd0, c}, 64'd1);
        chk("midrst sck",  {63'd0, s}, 64'd0);
        chk("midrst dout", {32'd0, q}, 64'd0);
        rst = 1'b0;
        xfer(0, 32'h3C3C_A5A5, 32'h0, 1'b1, 32'h3C3C_A5A5, -1, '0, "post_reset");
        rearm(0);

        // Parameter variant: 16 bit, CLK_DIV=1, CS_SETUP=2, MISO tied high.
        xfer(1, 32'h0000_8001, 32'hFFFF_FFFF, 1'b0, 32'h0000_FFFF, -1, '0, "variant");
        rearm(1);
        for (int i = 0; i < 3; i++) begin
            wd = $urandom;
            pt = $urandom;
            xfer(1, wd, pt, 1'b0, pt, -1, '0, $sformatf("vrand%0d", i));
            rearm(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
